// File: rtl/mm_pkg.sv
// Shared Mastermind definitions used by the code generator, scorer and display.
// Holds the game geometry and the generator FSM state encoding.
package mm_pkg;

    localparam int PEGS    = 4;
    localparam int COLORS  = 6;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_LOAD = 2'd2,
        S_SCAN = 2'd3
    } state_t;

endpackage

// File: rtl/secret_gen_if.sv
// Handshake bundle of the secret-code generator: game-side request/result
// signals plus the advance/word pair exchanged with the neighbouring RNG stage.
interface secret_gen_if #(
    parameter int PEGS    = mm_pkg::PEGS,
    parameter int COLOR_W = mm_pkg::COLOR_W
);
    logic                      start;
    logic                      unique_mode;
    logic                      rng_en;
    logic [31:0]               rng_res;
    logic [PEGS*COLOR_W-1:0]   code;
    logic                      valid;
    logic                      busy;

    modport master (
        output start, unique_mode, rng_res,
        input  rng_en, code, valid, busy
    );

    modport slave (
        input  start, unique_mode, rng_res,
        output rng_en, code, valid, busy
    );
endinterface

// File: rtl/secret_gen.sv
// Builds a Mastermind secret code by scanning 3-bit fields of RNG words,
// rejecting out-of-range (and, in unique mode, repeated) colours.
module secret_gen #(
    parameter int PEGS    = mm_pkg::PEGS,
    parameter int COLORS  = mm_pkg::COLORS,
    parameter int COLOR_W = mm_pkg::COLOR_W
) (
    input  logic            clk,
    input  logic            rst,
    secret_gen_if.slave     bus
);
    import mm_pkg::*;

    localparam int FIELDS = 10;
    localparam int CNT_W  = $clog2(PEGS + 1);

    localparam logic [1:0] IDLE = S_IDLE;
    localparam logic [1:0] REQ  = S_REQ;
    localparam logic [1:0] LOAD = S_LOAD;
    localparam logic [1:0] SCAN = S_SCAN;

    // Unique mode needs at least PEGS distinct colours or it would never finish.
    generate
        if (PEGS > COLORS) begin : g_bad_cfg
            $error("secret_gen: PEGS must not exceed COLORS");
        end
    endgenerate

    logic [1:0]              state_reg;
    logic                    uniq_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [7:0]              used_reg;
    logic [31:0]             word_reg;
    logic [3:0]              fidx_reg;
    logic [PEGS*COLOR_W-1:0] code_reg;
    logic                    valid_reg;

    logic [2:0] fields [FIELDS];
    logic [2:0] field;
    logic       accept;
    logic       last_peg;
    logic       unused_top;

    genvar gi;
    generate
        for (gi = 0; gi < FIELDS; gi++) begin : g_field
            assign fields[gi] = word_reg[3*gi +: 3];
        end
    endgenerate

    // Bits 31:30 of the RNG word never form a full field.
    assign unused_top = ^word_reg[31:30];

    assign field    = fields[fidx_reg];
    assign accept   = (int'(field) < COLORS) && !(uniq_reg && used_reg[field]);
    assign last_peg = (cnt_reg == CNT_W'(PEGS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            uniq_reg  <= 1'b0;
            cnt_reg   <= '0;
            used_reg  <= '0;
            word_reg  <= '0;
            fidx_reg  <= '0;
            code_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        uniq_reg  <= bus.unique_mode;
                        cnt_reg   <= '0;
                        used_reg  <= '0;
                        valid_reg <= 1'b0;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    state_reg <= LOAD;
                end
                LOAD: begin
                    word_reg  <= bus.rng_res;
                    fidx_reg  <= '0;
                    state_reg <= SCAN;
                end
                SCAN: begin
                    if (accept) begin
                        for (int i = 0; i < PEGS; i++) begin
                            if (cnt_reg == CNT_W'(i)) begin
                                code_reg[i*COLOR_W +: COLOR_W] <= COLOR_W'(field);
                            end
                        end
                        used_reg[field] <= 1'b1;
                        cnt_reg         <= cnt_reg + CNT_W'(1);
                    end
                    // Partial codes survive a word refill; only the word is replaced.
                    if (accept && last_peg) begin
                        valid_reg <= 1'b1;
                        state_reg <= IDLE;
                    end else if (fidx_reg == 4'(FIELDS - 1)) begin
                        state_reg <= REQ;
                    end else begin
                        fidx_reg <= fidx_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.rng_en = (state_reg == REQ);
    assign bus.busy   = (state_reg != IDLE);
    assign bus.code   = code_reg;
    assign bus.valid  = valid_reg;

endmodule

// File: tb/tb_secret_gen.sv
// Self-checking bench for secret_gen: directed table, randomized runs against
// a list-based reference model, and reset/start corner sequences.
module tb_secret_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    secret_gen_if #(.PEGS(4), .COLOR_W(3)) ifc ();

    secret_gen #(.PEGS(4), .COLORS(6), .COLOR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    localparam logic [31:0] FALLBACK = 32'h0002C688;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    logic [31:0] word_q [$];

    // RNG stand-in: one fresh word per advance request, visible by the LOAD cycle.
    always @(negedge clk) begin
        if (ifc.rng_en === 1'b1) begin
            pulses++;
            ifc.rng_res = (word_q.size() > 0) ? word_q.pop_front() : FALLBACK;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the words' colour fields, keep the acceptable ones in a list.
    function automatic void model(input bit uniq, input logic [31:0] w[$],
                                  output logic [11:0] code, output int lat, output int nw);
        int pegs [$];
        bit used [8];
        logic [31:0] word;
        int k;
        code = '0;
        lat  = 0;
        nw   = 0;
        k    = 0;
        for (int c = 0; c < 8; c++) used[c] = 1'b0;
        while (pegs.size() < 4) begin
            word = (k < w.size()) ? w[k] : FALLBACK;
            k++;
            nw++;
            lat += 2;
            for (int f = 0; f < 10 && pegs.size() < 4; f++) begin
                int c;
                c = int'((word >> (3 * f)) & 32'h7);
                lat++;
                if (c < 6 && !(uniq && used[c])) begin
                    pegs.push_back(c);
                    used[c] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) code = code | (12'(pegs[i]) << (3 * i));
    endfunction

    task automatic run_gen(input string tag, input bit uniq, input logic [31:0] words[$],
                           input bit hold, input logic [11:0] exp_code,
                           input int exp_lat, input int exp_pulses);
        int  lat;
        bit  done;
        word_q = words;
        pulses = 0;
        @(negedge clk);
        ifc.start       = 1'b1;
        ifc.unique_mode = uniq;
        @(posedge clk);
        #1;
        if (!hold) ifc.start = 1'b0;
        ifc.unique_mode = ~uniq;
        check({tag, " valid_drop"}, 32'(ifc.valid), 32'd0);
        check({tag, " busy_on"}, 32'(ifc.busy), 32'd1);
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (ifc.valid === 1'b1) done = 1'b1;
        end
        ifc.start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " code"}, 32'(ifc.code), 32'(exp_code));
        check({tag, " rng_pulses"}, 32'(pulses), 32'(exp_pulses));
        check({tag, " busy_off"}, 32'(ifc.busy), 32'd0);
        $display("[TB] %s uniq=%0d code=%h lat=%0d pulses=%0d", tag, uniq, ifc.code, lat, pulses);
    endtask

    typedef struct {
        bit          uniq;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nw;
        logic [11:0] code;
        int          lat;
        int          pulses;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        logic [31:0] words [$];
        logic [11:0] m_code;
        int m_lat, m_nw;
        bit uniq;

        vecs[0] = '{uniq: 1'b0, w0: 32'h00000688, w1: 32'h0, nw: 1, code: 12'h688, lat: 6,  pulses: 1};
        vecs[1] = '{uniq: 1'b0, w0: 32'h0001A237, w1: 32'h0, nw: 1, code: 12'h688, lat: 8,  pulses: 1};
        vecs[2] = '{uniq: 1'b1, w0: 32'h0000D912, w1: 32'h0, nw: 1, code: 12'h362, lat: 8,  pulses: 1};
        vecs[3] = '{uniq: 1'b0, w0: 32'hFFFFFFFF, w1: 32'h00000688, nw: 2, code: 12'h688, lat: 18, pulses: 2};
        vecs[4] = '{uniq: 1'b1, w0: 32'h00000000, w1: 32'h0002C688, nw: 2, code: 12'h688, lat: 18, pulses: 2};
        vecs[5] = '{uniq: 1'b0, w0: 32'h00000000, w1: 32'h0, nw: 1, code: 12'h000, lat: 6,  pulses: 1};

        rst             = 1'b1;
        ifc.start       = 1'b0;
        ifc.unique_mode = 1'b0;
        ifc.rng_res     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset code", 32'(ifc.code), 32'd0);
        check("reset valid", 32'(ifc.valid), 32'd0);
        check("reset busy", 32'(ifc.busy), 32'd0);
        check("reset rng_en", 32'(ifc.rng_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            words = {};
            words.push_back(vecs[i].w0);
            if (vecs[i].nw > 1) words.push_back(vecs[i].w1);
            run_gen($sformatf("vec%0d", i), vecs[i].uniq, words, 1'b0,
                    vecs[i].code, vecs[i].lat, vecs[i].pulses);
        end

        for (int r = 0; r < 20; r++) begin
            words = {};
            for (int k = 0; k < 4; k++) words.push_back($urandom);
            uniq = 1'($urandom_range(0, 1));
            model(uniq, words, m_code, m_lat, m_nw);
            run_gen($sformatf("rand%0d", r), uniq, words, 1'b0, m_code, m_lat, m_nw);
        end

        // Reset mid-SCAN after two accepts must clear everything at once.
        word_q = {32'h00000688};
        @(negedge clk);
        ifc.start       = 1'b1;
        ifc.unique_mode = 1'b0;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst code", 32'(ifc.code), 32'd0);
        check("async_rst valid", 32'(ifc.valid), 32'd0);
        check("async_rst busy", 32'(ifc.busy), 32'd0);
        check("async_rst rng_en", 32'(ifc.rng_en), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (5) @(negedge clk);
        check("post_rst no_pulse", 32'(pulses), 32'd0);
        check("post_rst idle", 32'(ifc.busy), 32'd0);
        $display("[TB] async reset mid-scan: code=%h busy=%0d", ifc.code, ifc.busy);
        words = {32'h000004E5};
        run_gen("after_rst", 1'b0, words, 1'b0, 12'h4E5, 6, 1);

        // rst and start together: reset dominates.
        @(negedge clk);
        rst       = 1'b1;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start busy", 32'(ifc.busy), 32'd0);
        check("rst_start valid", 32'(ifc.valid), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        ifc.start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start stays idle", 32'(ifc.busy), 32'd0);
        $display("[TB] rst+start: busy=%0d valid=%0d", ifc.busy, ifc.valid);

        // start held through the run, then a fresh start while valid is high.
        words = {32'h00000688};
        run_gen("hold_start", 1'b0, words, 1'b1, 12'h688, 6, 1);
        words = {32'h000004E5};
        run_gen("restart", 1'b1, words, 1'b0, 12'h4E5, 6, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
